// File: rtl/pipelined_controller_pkg.sv
// rtl/pipelined_controller_pkg.sv - shared opcode, EXE and COND codes plus the control bundle type
package pipelined_controller_pkg;

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_SLL  = 6'd9;
  localparam logic [5:0] OP_MULT = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  localparam logic [3:0] EXE_NO_OPERATION = 4'd0;
  localparam logic [3:0] EXE_ADD          = 4'd1;
  localparam logic [3:0] EXE_SUB          = 4'd2;
  localparam logic [3:0] EXE_AND          = 4'd3;
  localparam logic [3:0] EXE_SLL          = 4'd4;
  localparam logic [3:0] EXE_MULT         = 4'd5;

  localparam logic [1:0] COND_NONE = 2'd0;
  localparam logic [1:0] COND_JUMP = 2'd1;
  localparam logic [1:0] COND_BNE  = 2'd2;

  typedef enum logic {
    ST_RUN,
    ST_MULT_WAIT
  } state_t;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       branch_en;
    logic       jump_en;
    logic       is_imm;
    logic       st_or_bne;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic [1:0] branch_command;
  } ctrl_t;

endpackage

// File: rtl/pipelined_controller_op_decoder.sv
// rtl/pipelined_controller_op_decoder.sv - pure combinational opcode to control bundle decode
module op_decoder
  import pipelined_controller_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl,
  output logic            is_mult
);

  // Unknown opcodes fall through to an all-zero bundle, which the caller treats as a NOP.
  always_comb begin
    ctrl    = '0;
    is_mult = 1'b0;
    case (opcode)
      OP_W'(OP_ADD): begin ctrl.exe_cmd = EXE_ADD; ctrl.wb_en = 1'b1; end
      OP_W'(OP_SUB): begin ctrl.exe_cmd = EXE_SUB; ctrl.wb_en = 1'b1; end
      OP_W'(OP_AND): begin ctrl.exe_cmd = EXE_AND; ctrl.wb_en = 1'b1; end
      OP_W'(OP_SLL): begin ctrl.exe_cmd = EXE_SLL; ctrl.wb_en = 1'b1; end
      OP_W'(OP_ADDI): begin
        ctrl.exe_cmd = EXE_ADD;
        ctrl.wb_en   = 1'b1;
        ctrl.is_imm  = 1'b1;
      end
      OP_W'(OP_LD): begin
        ctrl.exe_cmd   = EXE_ADD;
        ctrl.wb_en     = 1'b1;
        ctrl.is_imm    = 1'b1;
        ctrl.st_or_bne = 1'b1;
        ctrl.mem_r_en  = 1'b1;
      end
      OP_W'(OP_ST): begin
        ctrl.exe_cmd   = EXE_ADD;
        ctrl.is_imm    = 1'b1;
        ctrl.st_or_bne = 1'b1;
        ctrl.mem_w_en  = 1'b1;
      end
      OP_W'(OP_BNE): begin
        ctrl.exe_cmd        = EXE_NO_OPERATION;
        ctrl.is_imm         = 1'b1;
        ctrl.st_or_bne      = 1'b1;
        ctrl.branch_en      = 1'b1;
        ctrl.branch_command = COND_BNE;
      end
      OP_W'(OP_JMP): begin
        ctrl.exe_cmd        = EXE_NO_OPERATION;
        ctrl.is_imm         = 1'b1;
        ctrl.branch_en      = 1'b1;
        ctrl.jump_en        = 1'b1;
        ctrl.branch_command = COND_JUMP;
      end
      OP_W'(OP_MULT): begin
        ctrl.exe_cmd = EXE_MULT;
        is_mult      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipelined_controller.sv
// rtl/pipelined_controller.sv - registered decode stage with multi-cycle multiply stall FSM
module pipelined_controller
  import pipelined_controller_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int CMD_W    = 4,
  parameter int MULT_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [OP_W-1:0]  opCode,
  input  logic             hazard_detected,
  input  logic             flush,
  output logic [CMD_W-1:0] EXE_CMD,
  output logic             branchEn,
  output logic             jumpEnable,
  output logic             Is_Imm,
  output logic             ST_or_BNE,
  output logic             WB_EN,
  output logic             MEM_R_EN,
  output logic             MEM_W_EN,
  output logic [1:0]       Branch_command,
  output logic             valid_out,
  output logic             stall_out,
  output logic             mult_busy
);

  localparam logic [3:0] CNT_LOAD = 4'(MULT_LAT - 1);

  ctrl_t      dec_ctrl;
  logic       dec_is_mult;
  ctrl_t      ctrl_q, ctrl_nx;
  logic       valid_q, valid_nx;
  logic       busy_q;
  state_t     state_q, state_nx;
  logic [3:0] cnt_q, cnt_nx;

  op_decoder #(.OP_W(OP_W)) u_dec (
    .opcode  (opCode),
    .ctrl    (dec_ctrl),
    .is_mult (dec_is_mult)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      ctrl_q  <= ctrl_nx;
      valid_q <= valid_nx;
      busy_q  <= (state_nx == ST_MULT_WAIT);
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    ctrl_nx  = '0;
    valid_nx = 1'b0;
    if (flush) begin
      state_nx = ST_RUN;
      cnt_nx   = 4'd0;
    end else if (state_q == ST_MULT_WAIT) begin
      cnt_nx = cnt_q - 4'd1;
      // Last wait cycle: emit the multiply writeback beat on the way out.
      if (cnt_q <= 4'd1) begin
        state_nx        = ST_RUN;
        cnt_nx          = 4'd0;
        ctrl_nx.exe_cmd = EXE_MULT;
        ctrl_nx.wb_en   = 1'b1;
        valid_nx        = 1'b1;
      end
    end else if (valid_in && !hazard_detected) begin
      ctrl_nx  = dec_ctrl;
      valid_nx = 1'b1;
      if (dec_is_mult) begin
        state_nx = ST_MULT_WAIT;
        cnt_nx   = CNT_LOAD;
      end
    end
  end

  assign stall_out = !flush && (hazard_detected || (state_q == ST_MULT_WAIT));

  assign EXE_CMD        = CMD_W'(ctrl_q.exe_cmd);
  assign branchEn       = ctrl_q.branch_en;
  assign jumpEnable     = ctrl_q.jump_en;
  assign Is_Imm         = ctrl_q.is_imm;
  assign ST_or_BNE      = ctrl_q.st_or_bne;
  assign WB_EN          = ctrl_q.wb_en;
  assign MEM_R_EN       = ctrl_q.mem_r_en;
  assign MEM_W_EN       = ctrl_q.mem_w_en;
  assign Branch_command = ctrl_q.branch_command;
  assign valid_out      = valid_q;
  assign mult_busy      = busy_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// tb/tb_pipelined_controller.sv - randomized and directed checks against a cycle-schedule model
module tb_pipelined_controller;
  import pipelined_controller_pkg::*;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic [5:0] opCode = '0;
  logic       hazard_detected = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] EXE_CMD;
  logic       branchEn, jumpEnable, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN;
  logic [1:0] Branch_command;
  logic       valid_out, stall_out, mult_busy;

  pipelined_controller #(.OP_W(6), .CMD_W(4), .MULT_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opCode(opCode),
    .hazard_detected(hazard_detected), .flush(flush),
    .EXE_CMD(EXE_CMD), .branchEn(branchEn), .jumpEnable(jumpEnable),
    .Is_Imm(Is_Imm), .ST_or_BNE(ST_or_BNE), .WB_EN(WB_EN),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .Branch_command(Branch_command),
    .valid_out(valid_out), .stall_out(stall_out), .mult_busy(mult_busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: a multiply accepted in cycle t owns cycles t+1..t+LAT-1 and writes back in t+LAT.
  int          cyc = 0;
  bit          m_act = 1'b0;
  int          wb_cyc = 0;
  bit          have_exp = 1'b0;
  logic [12:0] exp_vec = '0;
  logic        exp_valid = 1'b0;
  logic        exp_busy = 1'b0;

  // {exe[3:0], branchEn, jumpEnable, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN, cond[1:0]}
  function automatic logic [12:0] table_row(input logic [5:0] op);
    case (op)
      OP_ADD:  return {EXE_ADD,          7'b0000100, COND_NONE};
      OP_SUB:  return {EXE_SUB,          7'b0000100, COND_NONE};
      OP_AND:  return {EXE_AND,          7'b0000100, COND_NONE};
      OP_SLL:  return {EXE_SLL,          7'b0000100, COND_NONE};
      OP_ADDI: return {EXE_ADD,          7'b0010100, COND_NONE};
      OP_LD:   return {EXE_ADD,          7'b0011110, COND_NONE};
      OP_ST:   return {EXE_ADD,          7'b0011001, COND_NONE};
      OP_BNE:  return {EXE_NO_OPERATION, 7'b1011000, COND_BNE};
      OP_JMP:  return {EXE_NO_OPERATION, 7'b1110000, COND_JUMP};
      OP_MULT: return {EXE_MULT,         7'b0000000, COND_NONE};
      default: return 13'd0;
    endcase
  endfunction

  function automatic logic [12:0] dut_vec();
    return {EXE_CMD, branchEn, jumpEnable, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN,
            Branch_command};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  // One clock cycle: check last cycle's registered prediction, drive inputs, check stall, predict.
  task automatic step(input bit v, input logic [5:0] op, input bit hz, input bit fl, input bit r);
    bit busy_now;
    @(negedge clk);
    if (have_exp) begin
      chk("ctrl", 16'(dut_vec()), 16'(exp_vec));
      chk("valid_out", 16'(valid_out), 16'(exp_valid));
      chk("mult_busy", 16'(mult_busy), 16'(exp_busy));
    end
    valid_in = v; opCode = op; hazard_detected = hz; flush = fl; rst = r;
    #1;
    busy_now = m_act && (cyc < wb_cyc);
    if (have_exp) chk("stall_out", 16'(stall_out), 16'(!fl && (hz || busy_now)));
    exp_vec = '0;
    exp_valid = 1'b0;
    if (r || fl) begin
      m_act = 1'b0;
    end else if (busy_now) begin
      if (cyc + 1 == wb_cyc) begin
        exp_vec   = {EXE_MULT, 7'b0000100, COND_NONE};
        exp_valid = 1'b1;
        m_act     = 1'b0;
      end
    end else if (v && !hz) begin
      exp_vec   = table_row(op);
      exp_valid = 1'b1;
      if (op == OP_MULT) begin
        m_act  = 1'b1;
        wb_cyc = cyc + LAT;
      end
    end
    exp_busy = m_act && (cyc + 1 < wb_cyc);
    have_exp = 1'b1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [5:0] ops [10];

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_ADDI, OP_LD, OP_ST, OP_BNE, OP_JMP, OP_MULT};

    step(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("reset_valid", 16'(valid_out), 16'd0);
    chk("reset_busy", 16'(mult_busy), 16'd0);
    chk("reset_stall", 16'(stall_out), 16'd0);
    chk("reset_exe", 16'(EXE_CMD), 16'd0);

    step(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);
    idle();
    chk("add_exe", 16'(EXE_CMD), 16'd1);
    chk("add_wb", 16'(WB_EN), 16'd1);
    chk("add_valid", 16'(valid_out), 16'd1);

    step(1'b1, OP_MULT, 1'b0, 1'b0, 1'b0);
    idle();
    chk("mult_c1_exe", 16'(EXE_CMD), 16'd5);
    chk("mult_c1_wb", 16'(WB_EN), 16'd0);
    chk("mult_c1_stall", 16'(stall_out), 16'd1);
    chk("mult_c1_busy", 16'(mult_busy), 16'd1);
    idle();
    chk("mult_c2_valid", 16'(valid_out), 16'd0);
    idle();
    chk("mult_c3_stall", 16'(stall_out), 16'd1);
    idle();
    chk("mult_c4_exe", 16'(EXE_CMD), 16'd5);
    chk("mult_c4_wb", 16'(WB_EN), 16'd1);
    chk("mult_c4_valid", 16'(valid_out), 16'd1);
    chk("mult_c4_stall", 16'(stall_out), 16'd0);

    step(1'b1, OP_MULT, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("mflush_valid", 16'(valid_out), 16'd0);
    chk("mflush_busy", 16'(mult_busy), 16'd0);
    chk("mflush_stall", 16'(stall_out), 16'd0);
    repeat (LAT) idle();

    step(1'b1, OP_LD, 1'b1, 1'b0, 1'b0);
    chk("ld_hz_stall", 16'(stall_out), 16'd1);
    step(1'b1, OP_LD, 1'b0, 1'b0, 1'b0);
    chk("ld_hz_bubble", 16'(valid_out), 16'd0);
    idle();
    chk("ld_mem_r", 16'(MEM_R_EN), 16'd1);
    chk("ld_wb", 16'(WB_EN), 16'd1);
    chk("ld_imm", 16'(Is_Imm), 16'd1);

    step(1'b1, OP_JMP, 1'b0, 1'b1, 1'b0);
    idle();
    chk("jmp_flush_valid", 16'(valid_out), 16'd0);
    chk("jmp_flush_br", 16'(branchEn), 16'd0);

    step(1'b1, OP_MULT, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);
    chk("mrst_valid", 16'(valid_out), 16'd0);
    chk("mrst_busy", 16'(mult_busy), 16'd0);
    chk("mrst_stall", 16'(stall_out), 16'd0);
    idle();
    chk("mrst_add_exe", 16'(EXE_CMD), 16'd1);

    for (int i = 0; i < 3000; i++) begin
      int unsigned k;
      logic [5:0]  op;
      k  = $urandom_range(0, 12);
      op = (k < 10) ? ops[k] : 6'($urandom_range(0, 63));
      step($urandom_range(0, 9) < 8, op, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 2);
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipelined_controller.md
PIPELINED_CONTROLLER -- requirements
Module: pipelined_controller

Interface
REQ-001 Parameter OP_W, default 6, opcode width.
REQ-002 Parameter CMD_W, default 4, EXE_CMD width.
REQ-003 Parameter MULT_LAT, default 4, multiply latency in cycles; legal range 2..16.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 valid_in  in  1  opCode holds a real instruction this cycle.
REQ-008 opCode  in  OP_W  instruction opcode.
REQ-009 hazard_detected  in  1  data hazard; insert bubble.
REQ-010 flush  in  1  taken branch/jump; kill current decode and any multiply in flight.
REQ-011 EXE_CMD  out  CMD_W  registered ALU command.
REQ-012 Outputs branchEn, jumpEnable, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN: 1 bit each, registered; Branch_command: 2 bits, registered.
REQ-013 valid_out  out  1  registered controls describe a real instruction.
REQ-014 stall_out  out  1  combinational; upstream holds PC and IF/ID while high.
REQ-015 mult_busy  out  1  registered; high in MULT_WAIT.

Function
REQ-016 All control outputs are registered: an opcode accepted in cycle N appears on the outputs in cycle N+1.
REQ-017 Decode table:
- ADD, SUB, AND, SLL: matching EXE code, WB_EN=1.
- ADDI: EXE_ADD, WB_EN=1, Is_Imm=1.
- LD: EXE_ADD, WB_EN=1, Is_Imm=1, ST_or_BNE=1, MEM_R_EN=1.
- ST: EXE_ADD, Is_Imm=1, ST_or_BNE=1, MEM_W_EN=1.
- BNE: EXE_NO_OPERATION, Is_Imm=1, ST_or_BNE=1, branchEn=1, Branch_command=COND_BNE.
- JMP: EXE_NO_OPERATION, Is_Imm=1, branchEn=1, jumpEnable=1, Branch_command=COND_JUMP.
- MULT: EXE_MULT, WB_EN=0.
REQ-018 Unknown opcode: all controls 0, valid_out=1 (NOP).
REQ-019 Bubble (all controls 0, valid_out=0) is registered when: valid_in=0, hazard_detected=1, flush=1, or state is MULT_WAIT.
REQ-020 FSM has two states, RUN and MULT_WAIT. The 4-bit counter cnt is used only in MULT_WAIT.
REQ-021 In RUN, an accepted MULT (valid_in=1, hazard_detected=0, flush=0) registers the MULT controls and enters MULT_WAIT with cnt=MULT_LAT-1.
REQ-022 In MULT_WAIT: cnt decrements each cycle; stall_out=1; mult_busy=1.
REQ-023 When cnt reaches 1 in MULT_WAIT, the next registered output is a writeback beat (EXE_CMD=EXE_MULT, WB_EN=1, valid_out=1), and the FSM returns to RUN.
REQ-024 Total MULT occupancy is MULT_LAT cycles; stall_out is high for exactly MULT_LAT-1 cycles.
REQ-025 stall_out = hazard_detected OR (state==MULT_WAIT), gated low by flush.
REQ-026 Priority: rst > flush > MULT_WAIT > hazard_detected > normal decode.
REQ-027 Flush in MULT_WAIT: return to RUN, clear cnt, register a bubble; no writeback beat is produced.
REQ-028 hazard_detected in MULT_WAIT has no extra effect.
REQ-029 Back-to-back MULT: the second MULT is held by stall_out and accepted the cycle after the writeback beat.

Reset
REQ-030 On rst:
- All registered outputs 0, including valid_out and mult_busy.
- State=RUN, cnt=0.
- stall_out=0 in the cycle following reset.
REQ-031 rst during MULT_WAIT aborts the multiply with no writeback beat.

Structure
REQ-032 Opcode codes, EXE codes and COND codes live in the shared package alongside the existing defines.
REQ-033 Pure combinational decode is a sub-module, op_decoder (opcode -> control bundle).
REQ-034 This block adds the registers, FSM, counter and stall logic around op_decoder.

Verification
REQ-035 ADD with valid_in=1 in cycle 0:
- cycle 1: EXE_CMD=EXE_ADD, WB_EN=1, valid_out=1.
- all other controls 0.
REQ-036 MULT with MULT_LAT=4 in cycle 0:
- stall_out=1 in cycles 1-3; mult_busy=1 in cycles 1-3.
- cycle 1: EXE_MULT, WB_EN=0.
- cycles 2-3: bubble.
- cycle 4: EXE_MULT, WB_EN=1, valid_out=1.
REQ-037 MULT, then flush in cycle 2:
- cycle 3: bubble, mult_busy=0, stall_out=0.
- no WB_EN=1 beat ever appears.
REQ-038 LD with hazard_detected=1:
- next cycle: bubble, stall_out=1 combinationally.
- drop hazard: LD controls (MEM_R_EN=1, WB_EN=1, Is_Imm=1) appear one cycle later.
REQ-039 JMP with flush=1 in the same cycle: bubble registered (flush wins).
REQ-040 rst asserted in cycle 2 of a MULT:
- next cycle: all outputs 0, state RUN.
- a following ADD decodes normally.
